control_sequencer: RTL

- Hardwired control unit that drives the Datapath2 control inputs. It replaces hand-sequenced bench stimulus with a Moore FSM that steps fetch (T0–T2) and per-opcode execute states.
- Consumes the IR opcode field, the CON FF result and the memory ready handshake.
- Produces every bus-drive, register-load, register-select, ALU and memory strobe the datapath needs.

---
 rtl/control_sequencer_if.sv | 34 +++
 rtl/control_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_if
// Description : Control bundle between the hardwired sequencer and Datapath2.
// Revision    : 1.0 - initial release
// ============================================================================
interface control_sequencer_if;
    logic [4:0] ir_op;
    logic       con_ff;
    logic       mem_ready;

    logic       PCout, Zlowout, MDRout, BAout, Rout, Cout;
    logic       PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin;
    logic       Gra, Grb, Grc;
    logic       Read, Write;
    logic [4:0] OpCode;
    logic       run;
    logic       illegal;

    modport master (
        input  ir_op, con_ff, mem_ready,
        output PCout, Zlowout, MDRout, BAout, Rout, Cout,
        output PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin,
        output Gra, Grb, Grc, Read, Write, OpCode, run, illegal
    );

    modport slave (
        output ir_op, con_ff, mem_ready,
        input  PCout, Zlowout, MDRout, BAout, Rout, Cout,
        input  PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin,
        input  Gra, Grb, Grc, Read, Write, OpCode, run, illegal
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Moore-FSM hardwired control unit stepping fetch (T0-T2) and
//               per-opcode execute states. Optional macro: ILLEGAL_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter logic [4:0] ALU_ADD = 5'd2,
    parameter logic [4:0] ALU_SUB = 5'd4,
    parameter logic [4:0] ALU_INC = 5'd12
) (
    input  wire logic            clk,
    input  wire logic            clr_n,
    control_sequencer_if.master  bus
);

    localparam logic [4:0] c_op_ld   = 5'b00000;
    localparam logic [4:0] c_op_ldi  = 5'b00001;
    localparam logic [4:0] c_op_st   = 5'b00010;
    localparam logic [4:0] c_op_add  = 5'b00011;
    localparam logic [4:0] c_op_sub  = 5'b00100;
    localparam logic [4:0] c_op_addi = 5'b01100;
    localparam logic [4:0] c_op_br   = 5'b10010;
    localparam logic [4:0] c_op_jr   = 5'b10100;
    localparam logic [4:0] c_op_jal  = 5'b10101;
    localparam logic [4:0] c_op_nop  = 5'b11001;
    localparam logic [4:0] c_op_halt = 5'b11010;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,  S_T0  = 4'd1,  S_T1 = 4'd2,  S_T1W = 4'd3,
        S_T2   = 4'd4,  S_T3  = 4'd5,  S_T4 = 4'd6,  S_T5  = 4'd7,
        S_T6   = 4'd8,  S_T6W = 4'd9,  S_T7 = 4'd10, S_T7W = 4'd11,
        S_HALT = 4'd12
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_op;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_op    <= 5'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T2) r_op <= bus.ir_op;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_set_illegal;

    // Sticky until reset: the only way out of HALT is clr_n anyway.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)             r_illegal <= 1'b0;
        else if (w_set_illegal) r_illegal <= 1'b1;
    end

    assign bus.illegal = r_illegal;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.run = (r_state != S_IDLE) && (r_state != S_HALT);

    always_comb begin
        w_next      = r_state;
        bus.PCout   = 1'b0;
        bus.Zlowout = 1'b0;
        bus.MDRout  = 1'b0;
        bus.BAout   = 1'b0;
        bus.Rout    = 1'b0;
        bus.Cout    = 1'b0;
        bus.PCin    = 1'b0;
        bus.MARin   = 1'b0;
        bus.MDRin   = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.Zin     = 1'b0;
        bus.Rin     = 1'b0;
        bus.CONin   = 1'b0;
        bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;
        bus.Grc     = 1'b0;
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;
        bus.OpCode  = 5'd0;
`ifdef ILLEGAL_TRAP_EN
        w_set_illegal = 1'b0;
`endif
        case (r_state)
            S_IDLE: w_next = S_T0;
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.Zin = 1'b1;
                bus.OpCode = ALU_INC;
                w_next = S_T1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1;
                w_next = S_T1W;
            end
            S_T1W: begin
                bus.Read  = 1'b1;
                bus.MDRin = bus.mem_ready;
                if (bus.mem_ready) w_next = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                case (bus.ir_op)
                    c_op_halt: w_next = S_HALT;
                    c_op_nop:  w_next = S_T0;
                    c_op_ld, c_op_ldi, c_op_st, c_op_add, c_op_sub,
                    c_op_addi, c_op_br, c_op_jr, c_op_jal: w_next = S_T3;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        w_next        = S_HALT;
                        w_set_illegal = 1'b1;
`else
                        w_next = S_T0;
`endif
                    end
                endcase
            end
            S_T3: begin
                w_next = S_T4;
                case (r_op)
                    c_op_add, c_op_sub: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                    end
                    c_op_addi, c_op_ldi, c_op_ld, c_op_st: begin
                        bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                    end
                    c_op_br: begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
                    end
                    c_op_jr: begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
                        w_next = S_T0;
                    end
                    c_op_jal: begin
                        bus.PCout = 1'b1; bus.Grb = 1'b1; bus.Rin = 1'b1;
                    end
                    default: w_next = S_T0;
                endcase
            end
            S_T4: begin
                w_next = S_T5;
                case (r_op)
                    c_op_add, c_op_sub: begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
                        bus.OpCode = (r_op == c_op_add) ? ALU_ADD : ALU_SUB;
                    end
                    c_op_addi, c_op_ldi, c_op_ld, c_op_st: begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1; bus.OpCode = ALU_ADD;
                    end
                    c_op_br: begin
                        bus.PCout = 1'b1; bus.Yin = 1'b1;
                    end
                    c_op_jal: begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
                        w_next = S_T0;
                    end
                    default: w_next = S_T0;
                endcase
            end
            S_T5: begin
                w_next = S_T0;
                case (r_op)
                    c_op_add, c_op_sub, c_op_addi, c_op_ldi: begin
                        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end
                    c_op_ld: begin
                        bus.Zlowout = 1'b1; bus.MARin = 1'b1;
                        w_next = S_T6W;
                    end
                    c_op_st: begin
                        bus.Zlowout = 1'b1; bus.MARin = 1'b1;
                        w_next = S_T6;
                    end
                    c_op_br: begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1; bus.OpCode = ALU_ADD;
                        w_next = S_T6;
                    end
                    default: w_next = S_T0;
                endcase
            end
            S_T6: begin
                w_next = S_T0;
                case (r_op)
                    // Read stays low so the MDR input mux takes the bus value.
                    c_op_st: begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
                        w_next = S_T7W;
                    end
                    c_op_br: begin
                        bus.Zlowout = 1'b1; bus.PCin = bus.con_ff;
                    end
                    default: w_next = S_T0;
                endcase
            end
            S_T6W: begin
                bus.Read  = 1'b1;
                bus.MDRin = bus.mem_ready;
                if (bus.mem_ready) w_next = S_T7;
            end
            S_T7: begin
                bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                w_next = S_T0;
            end
            S_T7W: begin
                bus.Write = 1'b1;
                if (bus.mem_ready) w_next = S_T0;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
